uart_bus_master: RTL

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_master.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_bus_master.sv
// UART-driven bus master: decodes write (0x57) and read (0x52) command frames from a byte
// stream, runs one peripheral bus cycle, and answers over the UART sender.
module uart_bus_master #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_status,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, SEND, SEND_WAIT} state_t;

  state_t      state, state_n;
  logic        rx_prev;
  logic        rx_fire;
  logic        cmd_read;
  logic        last_byte;
  logic        tout;
  logic        err_n;
  logic [1:0]  cnt;
  logic [19:0] tcnt;
  logic [31:0] resp;

  assign rx_fire   = rx_status & ~rx_prev;
  assign tout      = (tcnt == TIMEOUT_CYCLES - 20'd1);
  assign last_byte = cmd_read ? (cnt == 2'd3) : (cnt == 2'd0);
  // The response register shifts left after each byte, so its top byte is always the one on the wire.
  assign tx_data   = resp[31:24];

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    busy    = (state != IDLE);
    case (state)
      IDLE: begin
        if (rx_fire) begin
          if (rx_data == 8'h57 || rx_data == 8'h52) state_n = ADDR;
          else err_n = 1'b1;
        end
      end
      ADDR: begin
        if (rx_fire) begin
          if (cnt == 2'd3) state_n = cmd_read ? BUS : DATA;
        end else if (tout) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      DATA: begin
        if (rx_fire) begin
          if (cnt == 2'd3) state_n = BUS;
        end else if (tout) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      BUS: begin
        rd      = cmd_read;
        wr      = ~cmd_read;
        state_n = SEND;
      end
      SEND: begin
        if (tx_en && !tx_status) state_n = SEND_WAIT;
      end
      SEND_WAIT: begin
        if (tx_status) state_n = last_byte ? IDLE : SEND;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rx_prev  <= 1'b0;
      err      <= 1'b0;
      tx_en    <= 1'b0;
      cmd_read <= 1'b0;
      cnt      <= 2'd0;
      tcnt     <= 20'd0;
      addr     <= 32'd0;
      wdata    <= 32'd0;
      resp     <= 32'd0;
    end else begin
      rx_prev <= rx_status;
      state   <= state_n;
      err     <= err_n;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            cmd_read <= (rx_data == 8'h52);
            cnt      <= 2'd0;
            tcnt     <= 20'd0;
          end
        end
        ADDR: begin
          if (rx_fire) begin
            addr <= {addr[23:0], rx_data};
            cnt  <= cnt + 2'd1;
            tcnt <= 20'd0;
          end else begin
            tcnt <= tcnt + 20'd1;
          end
        end
        DATA: begin
          if (rx_fire) begin
            wdata <= {wdata[23:0], rx_data};
            cnt   <= cnt + 2'd1;
            tcnt  <= 20'd0;
          end else begin
            tcnt <= tcnt + 20'd1;
          end
        end
        BUS: begin
          resp <= cmd_read ? rdata : {8'h4B, 24'h0};
          cnt  <= 2'd0;
        end
        SEND: begin
          // Raise the request only once the sender is idle; drop it once it reports busy.
          if (!tx_en && tx_status) tx_en <= 1'b1;
          else if (tx_en && !tx_status) tx_en <= 1'b0;
        end
        SEND_WAIT: begin
          if (tx_status && !last_byte) begin
            resp <= {resp[23:0], 8'h00};
            cnt  <= cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
